// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - shared state encoding and mode constants for the scan decoder
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_if.sv
// rtl/scan_decoder_if.sv - address offer/accept handshake between a requester and the scan decoder
interface scan_decoder_if #(
    parameter int AW = 4
);

    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a;

    modport master (
        output a_valid,
        output a,
        input  a_ready
    );

    modport slave (
        input  a_valid,
        input  a,
        output a_ready
    );

endinterface

// File: rtl/scan_decoder_onehot.sv
// rtl/scan_decoder_onehot.sv - combinational binary to one-hot decode with out-of-range flag
module scan_decoder_onehot #(
    parameter  int NOUT = 16,
    localparam int AW   = $clog2(NOUT)
) (
    input  logic [AW-1:0]   i_bin,
    output logic [NOUT-1:0] o_onehot,
    output logic            o_oor
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NOUT; i++) begin
            o_onehot[i] = (32'(i_bin) == i);
        end
    end

    // Non-power-of-two NOUT leaves codes in the address space with no output.
    assign o_oor = (32'(i_bin) >= NOUT);

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - one-hot output selector with direct addressing and timed scanning
// SCAN_DECODER_BLANK_EN: insert one all-zero cycle between consecutive scan outputs.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int NOUT  = 16,
    parameter  int DWELL = 1,
    localparam int AW    = $clog2(NOUT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    scan_decoder_if.slave   a_if,
    output logic [NOUT-1:0] y,
    output logic [AW-1:0]   idx,
    output logic            wrap,
    output logic            err
);

    localparam int DW = $clog2(DWELL + 1);

`ifdef SCAN_DECODER_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    state_t          r_state;
    logic [NOUT-1:0] r_y;
    logic [AW-1:0]   r_idx;
    logic            r_wrap;
    logic            r_err;
    logic [DW-1:0]   r_dwell;
    logic            r_blank;

    state_t          w_state_nx;
    logic [NOUT-1:0] w_y_nx;
    logic [AW-1:0]   w_idx_nx;
    logic            w_wrap_nx;
    logic            w_err_nx;
    logic [DW-1:0]   w_dwell_nx;
    logic            w_blank_nx;

    logic            w_a_ready;
    logic            w_at_last;
    logic [AW-1:0]   w_idx_inc;
    logic [AW-1:0]   w_dec_in;
    logic [NOUT-1:0] w_dec_y;
    logic            w_dec_oor;

    assign w_a_ready = !rst && en && (mode == MODE_DIRECT) && (r_state == DIRECT);
    assign w_at_last = (r_idx == AW'(NOUT - 1));
    assign w_idx_inc = w_at_last ? '0 : r_idx + 1'b1;

    // The single decoder serves the address in DIRECT and the upcoming index in SCAN;
    // after a blank cycle r_idx already holds the index to light.
    assign w_dec_in = (r_state == SCAN) ? (r_blank ? r_idx : w_idx_inc) : a_if.a;

    scan_decoder_onehot #(
        .NOUT (NOUT)
    ) u_onehot (
        .i_bin    (w_dec_in),
        .o_onehot (w_dec_y),
        .o_oor    (w_dec_oor)
    );

    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_idx_nx   = r_idx;
        w_wrap_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_dwell_nx = r_dwell;
        w_blank_nx = r_blank;

        if (!en) begin
            w_state_nx = IDLE;
            w_y_nx     = '0;
            w_idx_nx   = '0;
            w_dwell_nx = '0;
            w_blank_nx = 1'b0;
        end else if (mode == MODE_SCAN) begin
            w_state_nx = SCAN;
            if (r_state != SCAN) begin
                w_y_nx     = NOUT'(1);
                w_idx_nx   = '0;
                w_dwell_nx = '0;
                w_blank_nx = 1'b0;
            end else if (r_blank) begin
                w_y_nx     = w_dec_y;
                w_blank_nx = 1'b0;
                w_dwell_nx = '0;
            end else if (r_dwell == DW'(DWELL - 1)) begin
                w_idx_nx   = w_idx_inc;
                w_wrap_nx  = w_at_last;
                w_dwell_nx = '0;
                if (BLANK_EN) begin
                    w_y_nx     = '0;
                    w_blank_nx = 1'b1;
                end else begin
                    w_y_nx     = w_dec_y;
                end
            end else begin
                w_dwell_nx = r_dwell + 1'b1;
            end
        end else begin
            w_state_nx = DIRECT;
            w_dwell_nx = '0;
            w_blank_nx = 1'b0;
            if (r_state != DIRECT) begin
                w_y_nx = '0;
            end else if (a_if.a_valid && w_a_ready) begin
                if (w_dec_oor) begin
                    w_y_nx   = '0;
                    w_err_nx = 1'b1;
                end else begin
                    w_y_nx   = w_dec_y;
                    w_idx_nx = a_if.a;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
            r_dwell <= '0;
            r_blank <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_y     <= w_y_nx;
            r_idx   <= w_idx_nx;
            r_wrap  <= w_wrap_nx;
            r_err   <= w_err_nx;
            r_dwell <= w_dwell_nx;
            r_blank <= w_blank_nx;
        end
    end

    assign a_if.a_ready = w_a_ready;
    assign y            = r_y;
    assign idx          = r_idx;
    assign wrap         = r_wrap;
    assign err          = r_err;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - self-checking bench for scan_decoder (direct table, scan sequence, mid-scan events)
module tb_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       mode;

    logic [9:0] y0;
    logic [3:0] idx0;
    logic       wrap0;
    logic       err0;

    logic [3:0] y1;
    logic [1:0] idx1;
    logic       wrap1;
    logic       err1;

    int total = 0;
    int bad   = 0;

    scan_decoder_if #(.AW(4)) if0 ();
    scan_decoder_if #(.AW(2)) if1 ();

    scan_decoder #(.NOUT(10), .DWELL(2)) u0 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .a_if (if0),
        .y    (y0),
        .idx  (idx0),
        .wrap (wrap0),
        .err  (err0)
    );

    scan_decoder #(.NOUT(4), .DWELL(2)) u1 (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .a_if (if1),
        .y    (y1),
        .idx  (idx1),
        .wrap (wrap1),
        .err  (err1)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic       av;
        logic [3:0] a;
        logic       rdy;
        logic [9:0] y;
        logic [3:0] idx;
        logic       err;
    } vec_t;

    typedef struct {
        logic [9:0] y;
        logic [3:0] idx;
        logic       wrap;
        logic       err;
    } exp_t;

    localparam int NV = 16;
    localparam int NS = 15;

    vec_t vt [NV];
    exp_t sb [$];

`ifdef SCAN_DECODER_BLANK_EN
    int sy1 [NS] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1, 0};
    int si1 [NS] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    int sw1 [NS] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    localparam int K_IDX2 = 6;
`else
    int sy1 [NS] = '{1, 1, 2, 2, 4, 4, 8, 8, 1, 1, 2, 2, 4, 4, 8};
    int si1 [NS] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3};
    int sw1 [NS] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    localparam int K_IDX2 = 4;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input bit sel);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got output want queued entry", tag);
            return;
        end
        e = sb.pop_front();
        if (!sel) begin
            chk({tag, "_y"},    32'(y0),    32'(e.y));
            chk({tag, "_idx"},  32'(idx0),  32'(e.idx));
            chk({tag, "_wrap"}, 32'(wrap0), 32'(e.wrap));
            chk({tag, "_err"},  32'(err0),  32'(e.err));
        end else begin
            chk({tag, "_y"},    32'(y1),    32'(e.y));
            chk({tag, "_idx"},  32'(idx1),  32'(e.idx));
            chk({tag, "_wrap"}, 32'(wrap1), 32'(e.wrap));
            chk({tag, "_err"},  32'(err1),  32'(e.err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        //           en    mode  av    a      rdy   y        idx    err
        vt[0]  = '{1'b1, 1'b0, 1'b1, 4'd9,  1'b0, 10'h000, 4'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 4'd9,  1'b1, 10'h200, 4'd9, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 4'd3,  1'b1, 10'h200, 4'd9, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 4'd12, 1'b1, 10'h000, 4'd9, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 10'h000, 4'd9, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 4'd0,  1'b1, 10'h001, 4'd0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 4'd10, 1'b1, 10'h000, 4'd0, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 10'h000, 4'd0, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 4'd5,  1'b1, 10'h020, 4'd5, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 4'd8,  1'b1, 10'h100, 4'd8, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b1, 4'd2,  1'b0, 10'h000, 4'd0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b1, 4'd2,  1'b0, 10'h000, 4'd0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b1, 4'd2,  1'b1, 10'h004, 4'd2, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 10'h001, 4'd0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b1, 4'd7,  1'b0, 10'h000, 4'd0, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b1, 4'd7,  1'b1, 10'h080, 4'd7, 1'b0};

        // Reset held with the block enabled and an address offered.
        rst = 1'b1;
        en = 1'b1;
        mode = 1'b0;
        if0.a_valid = 1'b1;
        if0.a = 4'd9;
        if1.a_valid = 1'b0;
        if1.a = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst%0d_y0", i),   32'(y0),          32'd0);
            chk($sformatf("rst%0d_idx0", i), 32'(idx0),        32'd0);
            chk($sformatf("rst%0d_wrap0", i), 32'(wrap0),      32'd0);
            chk($sformatf("rst%0d_err0", i), 32'(err0),        32'd0);
            chk($sformatf("rst%0d_rdy0", i), 32'(if0.a_ready), 32'd0);
            chk($sformatf("rst%0d_y1", i),   32'(y1),          32'd0);
        end

        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            en = vt[i].en;
            mode = vt[i].mode;
            if0.a_valid = vt[i].av;
            if0.a = vt[i].a;
            sb.push_back('{vt[i].y, vt[i].idx, 1'b0, vt[i].err});
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(if0.a_ready), 32'(vt[i].rdy));
            tick();
            pop_chk($sformatf("v%0d", i), 1'b0);
        end

        // Scan sequence on the four-output instance, entered from DIRECT.
        mode = 1'b1;
        if0.a_valid = 1'b0;
        for (int k = 0; k < NS; k++) begin
            sb.push_back('{10'(sy1[k]), 4'(si1[k]), 1'(sw1[k]), 1'b0});
            tick();
            pop_chk($sformatf("scan%0d", k), 1'b1);
        end

        // Mid-scan events at idx=2 on the ten-output instance.
        for (int ev = 0; ev < 3; ev++) begin
            en = 1'b0;
            mode = 1'b0;
            if0.a_valid = 1'b0;
            tick();
            chk($sformatf("ev%0d_idle_y0", ev), 32'(y0), 32'd0);
            en = 1'b1;
            mode = 1'b1;
            for (int k = 0; k <= K_IDX2; k++) tick();
            chk($sformatf("ev%0d_at2_idx", ev), 32'(idx0), 32'd2);
            chk($sformatf("ev%0d_at2_y", ev),   32'(y0),   32'h004);
            case (ev)
                0: begin
                    en = 1'b0;
                    sb.push_back('{10'h000, 4'd0, 1'b0, 1'b0});
                    tick();
                    pop_chk("ev0_en_drop", 1'b0);
                end
                1: begin
                    rst = 1'b1;
                    mode = 1'b0;
                    if0.a_valid = 1'b1;
                    if0.a = 4'd3;
                    sb.push_back('{10'h000, 4'd0, 1'b0, 1'b0});
                    #1;
                    chk("ev1_rst_rdy", 32'(if0.a_ready), 32'd0);
                    tick();
                    pop_chk("ev1_rst", 1'b0);
                    chk("ev1_rst_y1",   32'(y1),   32'd0);
                    chk("ev1_rst_idx1", 32'(idx1), 32'd0);
                    rst = 1'b0;
                    if0.a_valid = 1'b0;
                end
                default: begin
                    mode = 1'b0;
                    if0.a_valid = 1'b1;
                    if0.a = 4'd1;
                    #1;
                    chk("ev2_mode_rdy", 32'(if0.a_ready), 32'd0);
                    tick();
                    chk("ev2_direct_y",   32'(y0),   32'd0);
                    chk("ev2_direct_err", 32'(err0), 32'd0);
                    chk("ev2_direct_rdy", 32'(if0.a_ready), 32'd1);
                    sb.push_back('{10'h002, 4'd1, 1'b0, 1'b0});
                    tick();
                    pop_chk("ev2_accept", 1'b0);
                    if0.a_valid = 1'b0;
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
